// File: rtl/lcd_frame_writer.sv
// Pixel stream to double-buffered framebuffer writer: tracks screen x/y from the
// PPU strobes, writes each pixel into the back bank and swaps banks per full frame.
module lcd_frame_writer #(
  parameter int unsigned WIDTH  = 160,
  parameter int unsigned HEIGHT = 144,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [1:0]        pixel_in,
  input  logic              pixel_valid_in,
  input  logic              hblank_in,
  input  logic              vblank_in,
  input  logic              lcd_on_in,
  output logic [ADDR_W-1:0] fb_addr_out,
  output logic [1:0]        fb_data_out,
  output logic              fb_we_out,
  output logic              front_buf_out,
  output logic              frame_done_out,
  output logic [7:0]        x_out,
  output logic [7:0]        y_out,
  output logic              short_line_out,
  output logic              overrun_out
);

  localparam logic [1:0] WAIT_FRAME = 2'd0;
  localparam logic [1:0] ACTIVE     = 2'd1;
  localparam logic [1:0] LINES_DONE = 2'd2;

  localparam int unsigned       BANK_SIZE  = WIDTH * HEIGHT;
  localparam logic [7:0]        X_END      = 8'(WIDTH);
  localparam logic [7:0]        Y_END      = 8'(HEIGHT);
  localparam logic [ADDR_W-1:0] LINE_STEP  = ADDR_W'(WIDTH);
  localparam logic [ADDR_W-1:0] BANK1_BASE = ADDR_W'(BANK_SIZE);

  logic [1:0]        state, state_d;
  logic              hblank_q, vblank_q;
  logic              hb_rise, vb_rise, vb_fall;
  logic [ADDR_W-1:0] line_base, line_base_d;
  logic [ADDR_W-1:0] back_base;
  logic [7:0]        x_d, y_d, x_acc;
  logic [ADDR_W-1:0] fb_addr_d;
  logic [1:0]        fb_data_d;
  logic              fb_we_d;
  logic              front_d, frame_done_d, short_d, overrun_d;

  assign hb_rise   = hblank_in & ~hblank_q;
  assign vb_rise   = vblank_in & ~vblank_q;
  assign vb_fall   = ~vblank_in & vblank_q;
  assign back_base = front_buf_out ? '0 : BANK1_BASE;

  // State, counters, flags and the registered RAM write port
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state          <= WAIT_FRAME;
      hblank_q       <= 1'b0;
      vblank_q       <= 1'b0;
      line_base      <= '0;
      x_out          <= '0;
      y_out          <= '0;
      fb_addr_out    <= '0;
      fb_data_out    <= '0;
      fb_we_out      <= 1'b0;
      front_buf_out  <= 1'b0;
      frame_done_out <= 1'b0;
      short_line_out <= 1'b0;
      overrun_out    <= 1'b0;
    end else begin
      state          <= state_d;
      hblank_q       <= hblank_in;
      vblank_q       <= vblank_in;
      line_base      <= line_base_d;
      x_out          <= x_d;
      y_out          <= y_d;
      fb_addr_out    <= fb_addr_d;
      fb_data_out    <= fb_data_d;
      fb_we_out      <= fb_we_d;
      front_buf_out  <= front_d;
      frame_done_out <= frame_done_d;
      short_line_out <= short_d;
      overrun_out    <= overrun_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state;
    line_base_d  = line_base;
    x_d          = x_out;
    y_d          = y_out;
    x_acc        = x_out;
    fb_addr_d    = fb_addr_out;
    fb_data_d    = fb_data_out;
    fb_we_d      = 1'b0;
    front_d      = front_buf_out;
    frame_done_d = 1'b0;
    short_d      = short_line_out;
    overrun_d    = overrun_out;

    if (!lcd_on_in) begin
      // LCD off abandons the frame; the front bank stays on display
      state_d     = WAIT_FRAME;
      x_d         = '0;
      y_d         = '0;
      line_base_d = '0;
    end else begin
      case (state)
        WAIT_FRAME: begin
          x_d         = '0;
          y_d         = '0;
          line_base_d = '0;
          if (pixel_valid_in) overrun_d = 1'b1;
          if (vb_fall) state_d = ACTIVE;
        end

        ACTIVE: begin
          if (pixel_valid_in) begin
            if (x_out < X_END) begin
              fb_we_d   = 1'b1;
              fb_addr_d = back_base + line_base + ADDR_W'(x_out);
              fb_data_d = pixel_in;
              x_acc     = x_out + 8'd1;
            end else begin
              overrun_d = 1'b1;
            end
          end
          x_d = x_acc;

          // Line end sees the pixel accepted in the same cycle
          if (hb_rise) begin
            if (x_acc != X_END) short_d = 1'b1;
            x_d         = '0;
            y_d         = y_out + 8'd1;
            line_base_d = line_base + LINE_STEP;
            if (y_d == Y_END) state_d = LINES_DONE;
          end

          if (vb_rise) begin
            if (state_d == LINES_DONE) begin
              front_d      = ~front_buf_out;
              frame_done_d = 1'b1;
            end else begin
              short_d = 1'b1;
            end
            state_d     = WAIT_FRAME;
            x_d         = '0;
            y_d         = '0;
            line_base_d = '0;
          end
        end

        LINES_DONE: begin
          if (pixel_valid_in) overrun_d = 1'b1;
          if (vb_rise) begin
            front_d      = ~front_buf_out;
            frame_done_d = 1'b1;
            state_d      = WAIT_FRAME;
            x_d          = '0;
            y_d          = '0;
            line_base_d  = '0;
          end
        end

        default: begin
          state_d     = WAIT_FRAME;
          x_d         = '0;
          y_d         = '0;
          line_base_d = '0;
        end
      endcase
    end
  end

endmodule
